// File: rtl/core_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_responder
// Purpose  : Memory-side responder for a single-cycle RV32I core. It holds
//            separate instruction and data memories with combinational word
//            reads and byte-masked synchronous stores. A boot-loader FSM
//            fills instruction memory from a valid/ready stream while the
//            core is held in reset, then releases the core.
// Ports    : clk, rst (async, active-low)
//            pc_address      -> instruction        : fetch port
//            write, mask_singal, alu_out_address,
//            store_data_out  -> load_data_in       : load/store port
//            boot_valid, boot_data, boot_last -> boot_ready : boot stream
//            core_hold : core reset request
//            addr_err  : sticky bad-fetch / out-of-range-store flag
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_responder #(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_address,
   output logic [31:0] instruction,
   input  logic        write,
   input  logic [3:0]  mask_singal,
   input  logic [31:0] alu_out_address,
   input  logic [31:0] store_data_out,
   output logic [31:0] load_data_in,
   input  logic        boot_valid,
   input  logic [31:0] boot_data,
   input  logic        boot_last,
   output logic        boot_ready,
   output logic        core_hold,
   output logic        addr_err
);

   localparam int          IW       = $clog2(IMEM_DEPTH);
   localparam int          DW       = $clog2(DMEM_DEPTH);
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [IW-1:0] PTR_LAST = IW'(IMEM_DEPTH - 1);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q;
   logic [IW-1:0] boot_ptr_q;
   logic          core_hold_q;
   logic          boot_ready_q;
   logic          addr_err_q;

   logic [31:0] imem_q [IMEM_DEPTH];
   logic [31:0] dmem_q [DMEM_DEPTH];

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [IW-1:0] w_imem_idx;
   logic [DW-1:0] w_dmem_idx;
   logic          w_fetch_ok;
   logic          w_dmem_in_range;
   logic          w_run;
   logic          w_boot_hs;
   logic          w_store_en;
   logic          w_unused_addr_lsbs;

   assign w_run           = (state_q == RUN);
   assign w_imem_idx      = pc_address[IW+1:2];
   assign w_dmem_idx      = alu_out_address[DW+1:2];
   assign w_fetch_ok      = (pc_address[1:0] == 2'b00) && (pc_address[31:IW+2] == '0);
   assign w_dmem_in_range = (alu_out_address[31:DW+2] == '0);
   // Byte lanes are selected by the mask; the low address bits carry no extra meaning.
   assign w_unused_addr_lsbs = ^alu_out_address[1:0];

   // Gated with rst so a stream word presented during reset cannot land in imem.
   assign w_boot_hs  = boot_valid && boot_ready_q && rst;
   assign w_store_en = w_run && write && w_dmem_in_range;

   // ------------------------------------------------------------------
   // Control FSM with registered handshake/hold outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= BOOT;
         boot_ptr_q   <= '0;
         core_hold_q  <= 1'b1;
         boot_ready_q <= 1'b1;
         addr_err_q   <= 1'b0;
      end else begin
         case (state_q)
            BOOT: begin
               if (w_boot_hs) begin
                  if (boot_last || (boot_ptr_q == PTR_LAST)) begin
                     // Pointer is left in place so it can never wrap.
                     state_q      <= RUN;
                     core_hold_q  <= 1'b0;
                     boot_ready_q <= 1'b0;
                  end else begin
                     boot_ptr_q <= boot_ptr_q + 1'b1;
                  end
               end
            end
            RUN: begin
               // Loads never flag: the ALU address is live every cycle.
               if (!w_fetch_ok || (write && !w_dmem_in_range)) begin
                  addr_err_q <= 1'b1;
               end
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Memories: not reset, contents survive rst
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_boot_hs) begin
         imem_q[boot_ptr_q] <= boot_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_store_en) begin
         for (int i = 0; i < 4; i++) begin
            if (mask_singal[i]) begin
               dmem_q[w_dmem_idx][8*i +: 8] <= store_data_out[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Combinational read ports
   // ------------------------------------------------------------------
   always_comb begin
      instruction = NOP;
      if (w_run && w_fetch_ok) begin
         instruction = imem_q[w_imem_idx];
      end
   end

   always_comb begin
      load_data_in = 32'h0;
      if (w_run && w_dmem_in_range) begin
         load_data_in = dmem_q[w_dmem_idx];
      end
   end

   assign boot_ready = boot_ready_q;
   assign core_hold  = core_hold_q;
   assign addr_err   = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_responder
// Purpose  : Directed bench for core_mem_responder. Stimulus pushes the
//            expected value of a chosen output into a queue; a monitor on the
//            falling edge pops each entry and compares it with the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int K_INSTR = 0;
   localparam int K_LOAD  = 1;
   localparam int K_HOLD  = 2;
   localparam int K_READY = 3;
   localparam int K_AERR  = 4;

   logic        clk;
   logic        rst;
   logic [31:0] pc_address;
   logic [31:0] instruction;
   logic        write;
   logic [3:0]  mask_singal;
   logic [31:0] alu_out_address;
   logic [31:0] store_data_out;
   logic [31:0] load_data_in;
   logic        boot_valid;
   logic [31:0] boot_data;
   logic        boot_last;
   logic        boot_ready;
   logic        core_hold;
   logic        addr_err;

   core_mem_responder #(
      .IMEM_DEPTH(256),
      .DMEM_DEPTH(256)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_address     (pc_address),
      .instruction    (instruction),
      .write          (write),
      .mask_singal    (mask_singal),
      .alu_out_address(alu_out_address),
      .store_data_out (store_data_out),
      .load_data_in   (load_data_in),
      .boot_valid     (boot_valid),
      .boot_data      (boot_data),
      .boot_last      (boot_last),
      .boot_ready     (boot_ready),
      .core_hold      (core_hold),
      .addr_err       (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  kind;
      logic [31:0] val;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   exp_t        m_e;
   string       m_n;
   logic [31:0] m_act;

   // Monitor: every queued expectation is compared at the falling edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         m_n = name_q.pop_front();
         case (int'(m_e.kind))
            K_INSTR: m_act = instruction;
            K_LOAD:  m_act = load_data_in;
            K_HOLD:  m_act = {31'h0, core_hold};
            K_READY: m_act = {31'h0, boot_ready};
            default: m_act = {31'h0, addr_err};
         endcase
         checks++;
         if (m_act !== m_e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", m_n, m_act, m_e.val);
         end
      end
   end

   task automatic expect_v(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.kind = 4'(kind);
      e.val  = val;
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic boot_word(input logic [31:0] d, input logic last);
      boot_valid = 1'b1;
      boot_data  = d;
      boot_last  = last;
      tick();
      boot_valid = 1'b0;
      boot_last  = 1'b0;
   endtask

   logic [31:0] words [3];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      pc_address = 32'h0; write = 1'b0; mask_singal = 4'h0;
      alu_out_address = 32'h0; store_data_out = 32'h0;
      boot_valid = 1'b0; boot_data = 32'h0; boot_last = 1'b0;
      tick();
      expect_v(K_HOLD,  32'd1, "reset_hold");
      expect_v(K_READY, 32'd1, "reset_ready");
      expect_v(K_AERR,  32'd0, "reset_aerr");
      expect_v(K_INSTR, NOP,   "reset_instr_nop");
      expect_v(K_LOAD,  32'h0, "reset_load_zero");
      tick();
      rst = 1'b1;

      // ---- Back-to-back boot of three words ----
      words[0] = 32'h0050_0093; words[1] = 32'h00A0_0113; words[2] = 32'h0020_81B3;
      for (int i = 0; i < 3; i++) begin
         expect_v(K_HOLD, 32'd1, "boot3_hold");
         boot_word(words[i], i == 2);
      end
      expect_v(K_HOLD,  32'd0, "boot3_release");
      expect_v(K_READY, 32'd0, "boot3_ready_low");
      pc_address = 32'h0;
      expect_v(K_INSTR, 32'h0050_0093, "boot3_pc0");
      tick();
      pc_address = 32'h8;
      expect_v(K_INSTR, 32'h0020_81B3, "boot3_pc8");
      tick();
      pc_address = 32'h4;
      expect_v(K_INSTR, 32'h00A0_0113, "boot3_pc4");
      expect_v(K_AERR,  32'd0, "boot3_no_err");
      tick();

      // ---- Boot with 5-cycle gaps ----
      do_reset();
      pc_address = 32'h0;
      words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
      for (int i = 0; i < 3; i++) begin
         boot_word(words[i], i == 2);
         if (i < 2) begin
            for (int g = 0; g < 5; g++) begin
               boot_data = 32'hBAD0_0000 | 32'(g);
               expect_v(K_HOLD, 32'd1, "gap_hold");
               tick();
            end
         end
      end
      expect_v(K_HOLD, 32'd0, "gap_release");
      expect_v(K_INSTR, 32'h1111_1111, "gap_pc0");
      tick();
      pc_address = 32'h4;
      expect_v(K_INSTR, 32'h2222_2222, "gap_pc4");
      tick();
      pc_address = 32'h8;
      expect_v(K_INSTR, 32'h3333_3333, "gap_pc8");
      tick();
      // Misaligned fetch: NOP now, sticky error afterwards.
      pc_address = 32'h2;
      expect_v(K_INSTR, NOP, "misalign_nop");
      expect_v(K_AERR, 32'd0, "misalign_err_before");
      tick();
      pc_address = 32'h0;
      expect_v(K_AERR, 32'd1, "misalign_err_set");
      tick(); tick();
      expect_v(K_AERR, 32'd1, "misalign_err_sticky");
      tick();

      // ---- Full-depth boot, no boot_last ----
      do_reset();
      expect_v(K_AERR, 32'd0, "full_err_cleared");
      for (int i = 0; i < 256; i++) begin
         if (i == 255) expect_v(K_HOLD, 32'd1, "full_hold_before_last");
         boot_word(32'hC0DE_0000 | 32'(i), 1'b0);
      end
      expect_v(K_HOLD,  32'd0, "full_release");
      expect_v(K_READY, 32'd0, "full_ready_low");
      boot_valid = 1'b1;
      boot_data  = 32'hDEAD_BEEF;
      tick();
      boot_valid = 1'b0;
      expect_v(K_READY, 32'd0, "full_257_not_ready");
      pc_address = 32'h0;
      expect_v(K_INSTR, 32'hC0DE_0000, "full_pc0");
      tick();
      pc_address = 32'h3FC;
      expect_v(K_INSTR, 32'hC0DE_00FF, "full_pc3fc");
      tick();
      pc_address = 32'h0;

      // ---- Byte-masked stores ----
      write = 1'b1; mask_singal = 4'hF;
      alu_out_address = 32'h10; store_data_out = 32'hAABB_CCDD;
      tick();
      alu_out_address = 32'h0; store_data_out = 32'h0102_0304;
      tick();
      alu_out_address = 32'h10; store_data_out = 32'h1122_3344; mask_singal = 4'b0110;
      expect_v(K_LOAD, 32'hAABB_CCDD, "rdw_old_data");
      tick();
      write = 1'b0; mask_singal = 4'h0;
      expect_v(K_LOAD, 32'hAA22_33DD, "masked_store");
      tick();
      write = 1'b1; mask_singal = 4'h0; store_data_out = 32'hFFFF_FFFF;
      tick();
      write = 1'b0;
      expect_v(K_LOAD, 32'hAA22_33DD, "mask0_noop");
      expect_v(K_AERR, 32'd0, "stores_no_err");
      tick();

      // ---- Out-of-range store and fetch ----
      write = 1'b1; mask_singal = 4'hF;
      alu_out_address = 32'h400; store_data_out = 32'h5555_5555;
      pc_address = 32'h400;
      expect_v(K_LOAD, 32'h0, "oor_load_zero");
      expect_v(K_INSTR, NOP, "oor_fetch_nop");
      tick();
      write = 1'b0; pc_address = 32'h0; alu_out_address = 32'h0;
      expect_v(K_LOAD, 32'h0102_0304, "oor_store_ignored");
      expect_v(K_AERR, 32'd1, "oor_err_set");
      tick();
      pc_address = 32'h2;
      expect_v(K_INSTR, NOP, "pc2_nop");
      tick();
      pc_address = 32'h0;
      tick(); tick();
      expect_v(K_AERR, 32'd1, "oor_err_sticky");
      tick();

      // ---- Async reset mid-RUN, then reboot one word ----
      rst = 1'b0;
      #1;
      expect_v(K_HOLD,  32'd1, "arst_hold");
      expect_v(K_READY, 32'd1, "arst_ready");
      expect_v(K_AERR,  32'd0, "arst_err_clear");
      expect_v(K_INSTR, NOP,   "arst_instr_nop");
      tick();
      rst = 1'b1;
      boot_word(32'hFEED_F00D, 1'b1);
      expect_v(K_HOLD, 32'd0, "reboot_release");
      pc_address = 32'h0; alu_out_address = 32'h10;
      expect_v(K_INSTR, 32'hFEED_F00D, "reboot_pc0");
      expect_v(K_LOAD, 32'hAA22_33DD, "keep_dmem4");
      tick();
      pc_address = 32'h4; alu_out_address = 32'h0;
      expect_v(K_INSTR, 32'hC0DE_0001, "keep_imem1");
      expect_v(K_LOAD, 32'h0102_0304, "keep_dmem0");
      tick();
      tick();

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Memory-side responder for the single-cycle RV32I core.
- Serves the core's instruction fetch and its load/store port: combinational word reads, and byte-masked synchronous writes.
- Contains a boot-loader FSM that fills instruction memory over a valid/ready stream while holding the core in reset, then releases the core.
- Sits at top level beside the core; its ports connect directly to the core's memory-side ports.

Parameters:
IMEM_DEPTH, 256, instruction memory size in 32-bit words (power of two)
DMEM_DEPTH, 256, data memory size in 32-bit words (power of two)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
pc_address  input  32  core fetch byte address
instruction  output  32  fetched instruction word to core
write  input  1  core store strobe
mask_singal  input  4  core byte-lane enables, bit i = byte lane i
alu_out_address  input  32  core load/store byte address
store_data_out  input  32  core store data, already lane-aligned
load_data_in  output  32  raw data word to core (core extracts/extends)
boot_valid  input  1  boot word available
boot_data  input  32  boot word
boot_last  input  1  qualifies final boot word
boot_ready  output  1  responder accepts boot word
core_hold  output  1  1 = core must be held in reset
addr_err  output  1  sticky out-of-range/misaligned access flag

Behaviour:
- States: BOOT, RUN. Reset (rst=0, async) forces:
  - BOOT, boot_ptr=0, addr_err=0.
  - Memory contents are NOT reset and are retained across resets.
- BOOT:
  - core_hold=1, boot_ready=1.
  - Handshake = boot_valid&boot_ready at a rising edge: imem[boot_ptr]<=boot_data; boot_ptr<=boot_ptr+1.
  - Go to RUN on a handshake with boot_last=1, or on the handshake writing word IMEM_DEPTH-1, whichever comes first. boot_ptr never wraps.
  - No handshake: state is held; a boot_valid stall of any length is legal.
  - instruction=32'h00000013 (NOP) and load_data_in=0.
  - write is ignored.
- RUN:
  - core_hold=0, boot_ready=0. boot_valid is ignored.
  - The core is released on the first edge after the transition; the first fetch is at pc_address=0.
  - Leaving RUN requires rst only.
- Fetch (RUN, combinational, zero latency):
  - instruction=imem[pc_address>>2].
  - If pc_address[1:0]!=0 or the word index is >=IMEM_DEPTH: instruction=NOP, and addr_err<=1 at the next edge.
- Load (RUN, combinational):
  - load_data_in=dmem[alu_out_address>>2], full word, independent of mask_singal.
  - An out-of-range index returns 0. Loads alone do not set addr_err, because the address is always live from the ALU.
- Store (RUN, write=1):
  - At the rising edge, for each i with mask_singal[i]=1: dmem[idx] byte i <= store_data_out byte i. Unmasked lanes are unchanged.
  - mask_singal=0 with write=1 is a no-op.
  - An out-of-range idx ignores the write and sets addr_err.
- Read/write timing:
  - Read-during-write to the same word returns the old data until the edge.
  - A store and a load to the same word in consecutive cycles: the load sees the new data.
- addr_err is sticky until rst.
- Data memory and instruction memory are separate arrays. The core cannot write imem.

Test Plan:
- Reset, then stream 3 words 0x00500093, 0x00A00113, 0x002081B3 with boot_last on the 3rd.
  - Required: core_hold=1 throughout, then 0 the cycle after the 3rd handshake.
  - Required: instruction=0x00500093 at pc=0 and 0x002081B3 at pc=8.
- Boot with gaps (boot_valid low for 5 cycles between words).
  - Required: boot_ptr advances only on handshakes; contents correct; no early RUN.
- Stream IMEM_DEPTH words with boot_last never asserted.
  - Required: RUN entered after word 255; a 257th boot_valid is not accepted (boot_ready=0).
- RUN, dmem[4]=0xAABBCCDD, store store_data_out=0x11223344 with mask 4'b0110 to address 0x10.
  - Required: load at 0x10 next cycle returns 0xAA2233DD.
- RUN, store to address 0x400 (index 256), and fetch at pc=0x2.
  - Required: write ignored; instruction=0x00000013; addr_err=1 and stays 1 until rst.
- Assert rst low mid-RUN for 1 cycle.
  - Required: core_hold=1 and boot_ready=1 immediately (async); addr_err=0.
  - Required: dmem and imem contents preserved, visible after reboot.
